fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 111 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  // Arbiter control state: IDLE picks a new owner, BURST holds the port.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Index width for n items (ID_W = $clog2(NUM_REQ)); never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first asserted request strictly after ptr,
// wrapping around so that ptr itself has the lowest priority.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  // Scan ptr+1 .. ptr+N (mod N) and keep the first hit.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any = 1'b1;
        idx = ID_W'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the async FIFO write port among
// NUM_REQ valid/ready producers. Fully combinational path to the FIFO.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int DATA_SIZE = 12,
  parameter  int NUM_REQ   = 4,
  parameter  int MAX_BURST = 4,
  parameter  int CNT_W     = 16,
  localparam int ID_W      = id_w(NUM_REQ)
) (
  input  logic                         wclk,
  input  logic                         wrst,
  input  logic                         arb_en,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         wFull,
  output logic                         winc,
  output logic [DATA_SIZE-1:0]         wData,
  output logic [ID_W-1:0]              grant_id,
  output logic                         busy,
  output logic [CNT_W-1:0]             wr_count
);

  // Counter must hold values up to MAX_BURST-1 plus the post-beat increment.
  localparam int BC_W = id_w(MAX_BURST + 1);

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0] grant_nxt;
  logic [BC_W-1:0] burst_cnt, burst_cnt_nxt;
  logic [ID_W-1:0] pick_idx, cand;
  logic            pick_any, cand_ok, beat;

  rr_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Candidate selection and handshake toward producers and the FIFO.
  always_comb begin
    cand    = (state == BURST) ? grant_id : pick_idx;
    cand_ok = (state == BURST) || (arb_en && pick_any);
    req_ready = '0;
    if (wrst && !wFull && cand_ok) req_ready[cand] = 1'b1;
    beat  = |(req_valid & req_ready);
    winc  = beat;
    wData = beat ? req_data[cand*DATA_SIZE +: DATA_SIZE] : '0;
    busy  = wrst && ((state == BURST) || beat);
  end

  // Next-state logic: lock on first beat, rotate on burst end or release.
  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    grant_nxt     = grant_id;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (beat) begin
          grant_nxt     = cand;
          burst_cnt_nxt = BC_W'(1);
          if (MAX_BURST == 1) rr_ptr_nxt = cand;
          else                state_nxt  = BURST;
        end
      end
      BURST: begin
        if (beat) begin
          if (burst_cnt == BC_W'(MAX_BURST - 1)) begin
            rr_ptr_nxt    = grant_id;
            burst_cnt_nxt = '0;
            state_nxt     = IDLE;
          end else begin
            burst_cnt_nxt = burst_cnt + 1'b1;
          end
        end else if (!req_valid[grant_id]) begin
          // Owner ran dry: give the port back; a full FIFO just stalls.
          rr_ptr_nxt    = grant_id;
          burst_cnt_nxt = '0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, pointer, grant and beat counter registers.
  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      state     <= IDLE;
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      burst_cnt <= '0;
      grant_id  <= '0;
      wr_count  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
      grant_id  <= grant_nxt;
      wr_count  <= wr_count + CNT_W'(beat);
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scoreboard bench for fifo_wr_arbiter.
module tb_fifo_wr_arbiter;

  localparam int DS = 12;
  localparam int NR = 4;
  localparam int MB = 4;
  localparam int CW = 16;

  logic             wclk, wrst, arb_en, wFull;
  logic [NR-1:0]    req_valid, req_ready;
  logic [NR*DS-1:0] req_data;
  logic             winc, busy;
  logic [DS-1:0]    wData;
  logic [1:0]       grant_id;
  logic [CW-1:0]    wr_count;

  typedef struct packed {
    logic [1:0]    id;
    logic [DS-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DS-1:0] src_data[NR][16];
  int            src_len[NR];
  int            src_head[NR];
  int            tests_run    = 0;
  int            tests_failed = 0;

  logic          s_winc, s_busy;
  logic [NR-1:0] s_ready;
  logic [1:0]    s_gid;
  logic [CW-1:0] s_cnt;

  fifo_wr_arbiter #(
    .DATA_SIZE (DS),
    .NUM_REQ   (NR),
    .MAX_BURST (MB),
    .CNT_W     (CW)
  ) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .arb_en    (arb_en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wFull     (wFull),
    .winc      (winc),
    .wData     (wData),
    .grant_id  (grant_id),
    .busy      (busy),
    .wr_count  (wr_count)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]         = (src_head[i] < src_len[i]);
      req_data[i*DS +: DS] = req_valid[i] ? src_data[i][src_head[i]] : '0;
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < NR; i++) begin
      src_len[i]  = 0;
      src_head[i] = 0;
    end
  endtask

  task automatic load(input int id, input logic [DS-1:0] d);
    src_data[id][src_len[id]] = d;
    src_len[id]++;
  endtask

  task automatic push(input int id, input logic [DS-1:0] d);
    exp_t e;
    e.id   = 2'(id);
    e.data = d;
    exp_q.push_back(e);
  endtask

  // One clock: sample at negedge, score any beat, retire accepted words.
  task automatic cycle();
    logic [NR-1:0] take;
    exp_t          e;
    @(negedge wclk);
    s_winc  = winc;
    s_ready = req_ready;
    s_gid   = grant_id;
    s_busy  = busy;
    s_cnt   = wr_count;
    if (winc === 1'b1) begin
      check("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("beat_data", 32'(wData), 32'(e.data));
        check("beat_owner", 32'(req_ready), 32'(4'b0001 << e.id));
      end
    end
    take = req_valid & req_ready;
    @(posedge wclk);
    #1;
    for (int i = 0; i < NR; i++) if (take[i]) src_head[i]++;
    drive();
  endtask

  task automatic do_reset();
    clear_src();
    exp_q.delete();
    drive();
    wrst = 1'b0;
    repeat (2) @(posedge wclk);
    #1;
    wrst = 1'b1;
  endtask

  initial begin
    logic [6:0] pat;

    // Test 1: reset hold, then idle.
    wrst = 1'b0; arb_en = 1'b1; wFull = 1'b0;
    clear_src();
    drive();
    repeat (10) @(posedge wclk);
    #1;
    check("t1_rst_winc", 32'(winc), 32'd0);
    check("t1_rst_busy", 32'(busy), 32'd0);
    wrst = 1'b1;
    cycle();
    check("t1_winc", 32'(s_winc), 32'd0);
    check("t1_ready", 32'(s_ready), 32'd0);
    check("t1_busy", 32'(s_busy), 32'd0);
    check("t1_count", 32'(s_cnt), 32'd0);
    check("t1_gid", 32'(s_gid), 32'd0);

    // Test 2: single requester, burst boundary with no bubble.
    clear_src();
    for (int k = 1; k <= 6; k++) begin
      load(1, DS'(12'h0A0 + k));
      push(1, DS'(12'h0A0 + k));
    end
    drive();
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("t2_winc", 32'(s_winc), 32'd1);
    end
    cycle();
    check("t2_idle", 32'(s_winc), 32'd0);
    check("t2_gid", 32'(s_gid), 32'd1);
    check("t2_count", 32'(s_cnt), 32'd6);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Test 3: all requesters, full bursts rotate 0,1,2,3,0,1,2,3.
    do_reset();
    for (int g = 0; g < NR; g++)
      for (int j = 0; j < 8; j++) load(g, DS'(g*256 + 'hC0 + j));
    for (int r = 0; r < 2; r++)
      for (int g = 0; g < NR; g++)
        for (int b = 0; b < MB; b++) push(g, DS'(g*256 + 'hC0 + r*4 + b));
    drive();
    for (int k = 0; k < 32; k++) begin
      cycle();
      check("t3_winc", 32'(s_winc), 32'd1);
    end
    cycle();
    check("t3_idle", 32'(s_winc), 32'd0);
    check("t3_count", 32'(s_cnt), 32'd32);
    check("t3_gid", 32'(s_gid), 32'd3);
    check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Test 4: wFull stall mid-burst keeps grant and beat count.
    clear_src();
    for (int k = 1; k <= 4; k++) begin load(2, DS'(12'h2B0 + k)); push(2, DS'(12'h2B0 + k)); end
    for (int k = 1; k <= 2; k++) load(3, DS'(12'h3B0 + k));
    for (int k = 1; k <= 2; k++) push(3, DS'(12'h3B0 + k));
    drive();
    repeat (2) begin
      cycle();
      check("t4_pre_winc", 32'(s_winc), 32'd1);
    end
    wFull = 1'b1;
    repeat (3) begin
      cycle();
      check("t4_stall_winc", 32'(s_winc), 32'd0);
      check("t4_stall_ready", 32'(s_ready), 32'd0);
      check("t4_stall_gid", 32'(s_gid), 32'd2);
      check("t4_stall_busy", 32'(s_busy), 32'd1);
    end
    wFull = 1'b0;
    repeat (2) begin
      cycle();
      check("t4_post_owner", 32'(s_ready), 32'b0100);
    end
    repeat (2) begin
      cycle();
      check("t4_rot_owner", 32'(s_ready), 32'b1000);
    end
    repeat (2) cycle();
    check("t4_count", 32'(s_cnt), 32'd38);
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Test 5: early release costs exactly one idle cycle.
    clear_src();
    for (int k = 1; k <= 2; k++) begin load(0, DS'(12'h0C0 + k)); push(0, DS'(12'h0C0 + k)); end
    for (int k = 1; k <= 3; k++) begin load(3, DS'(12'h3C0 + k)); push(3, DS'(12'h3C0 + k)); end
    drive();
    pat = 7'b0111011;
    for (int k = 0; k < 7; k++) begin
      cycle();
      check("t5_winc_pattern", 32'(s_winc), 32'(pat[k]));
    end
    check("t5_count", 32'(s_cnt), 32'd43);
    check("t5_gid", 32'(s_gid), 32'd3);
    check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // Test 6: asynchronous reset mid-burst, then arb_en gating.
    clear_src();
    for (int k = 1; k <= 4; k++) load(1, DS'(12'h1D0 + k));
    for (int k = 1; k <= 2; k++) push(1, DS'(12'h1D0 + k));
    drive();
    repeat (2) cycle();
    #2;
    wrst = 1'b0;
    #1;
    check("t6_async_winc", 32'(winc), 32'd0);
    check("t6_async_ready", 32'(req_ready), 32'd0);
    check("t6_async_busy", 32'(busy), 32'd0);
    check("t6_async_wdata", 32'(wData), 32'd0);
    check("t6_async_count", 32'(wr_count), 32'd0);
    check("t6_sb_empty_rst", 32'(exp_q.size()), 32'd0);
    clear_src();
    drive();
    @(posedge wclk);
    #1;
    wrst = 1'b1;
    arb_en = 1'b0;
    for (int g = 0; g < NR; g++)
      for (int j = 1; j <= 2; j++) load(g, DS'(g*256 + 'hE0 + j));
    drive();
    repeat (3) begin
      cycle();
      check("t6_gated_winc", 32'(s_winc), 32'd0);
      check("t6_gated_ready", 32'(s_ready), 32'd0);
    end
    check("t6_restart_count", 32'(s_cnt), 32'd0);
    check("t6_restart_gid", 32'(s_gid), 32'd0);
    arb_en = 1'b1;
    for (int g = 0; g < NR; g++)
      for (int j = 1; j <= 2; j++) push(g, DS'(g*256 + 'hE0 + j));
    cycle();
    check("t6_first_owner", 32'(s_ready), 32'b0001);
    repeat (11) cycle();
    check("t6_count", 32'(s_cnt), 32'd8);
    check("t6_gid", 32'(s_gid), 32'd3);
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
